// File: rtl/pipe_register.sv
// pipe_register: elastic pipeline register chain with valid/ready handshake,
// bubble collapsing and synchronous flush.
// Optional feature: define PIPE_REG_COUNT_EN to add the occupancy output `count`.
module pipe_register #(
  parameter int unsigned     WIDTH     = 32,
  parameter int unsigned     STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
`ifdef PIPE_REG_COUNT_EN
  output logic [$clog2(STAGES+1)-1:0]  count,
`endif
  output logic [WIDTH-1:0]             out_data
);

  if (STAGES < 1) begin : g_illegal_stages
    $error("pipe_register: STAGES must be at least 1");
  end

  logic [STAGES-1:0] r_valid;
  logic [WIDTH-1:0]  r_data [STAGES];

  logic [STAGES-1:0] w_take;
  logic [STAGES-1:0] w_src_valid;
  logic [WIDTH-1:0]  w_src_data [STAGES];

  // A stage may load when it is empty or the stage after it is moving.
  always_comb begin
    logic t;
    t = out_ready;
    w_take = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      t = !r_valid[i] | t;
      w_take[i] = t;
    end
  end

  // Source of each stage: upstream port for stage 0, previous stage otherwise.
  always_comb begin
    w_src_valid[0] = in_valid;
    w_src_data[0]  = in_data;
    for (int i = 1; i < STAGES; i++) begin
      w_src_valid[i] = r_valid[i-1];
      w_src_data[i]  = r_data[i-1];
    end
  end

  // Valid bits: flush empties every stage; otherwise moving stages take their source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (flush) begin
      r_valid <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (w_take[i]) r_valid[i] <= w_src_valid[i];
      end
    end
  end

  // Payload: only overwritten by a real beat so bubbles leave data untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) r_data[i] <= RESET_VAL;
    end else if (!flush) begin
      for (int i = 0; i < STAGES; i++) begin
        if (w_take[i] && w_src_valid[i]) r_data[i] <= w_src_data[i];
      end
    end
  end

  assign in_ready  = w_take[0] & !flush;
  assign out_valid = r_valid[STAGES-1];
  assign out_data  = r_data[STAGES-1];

`ifdef PIPE_REG_COUNT_EN
  localparam int unsigned CW = $clog2(STAGES + 1);
  localparam logic [CW-1:0] CntOne = CW'(1);

  logic          r_count;
  logic [CW-1:0] r_occ;
  logic          w_in_xfer;
  logic          w_out_xfer;

  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready & !flush;

  // Occupancy tracks transfers; simultaneous in and out leaves it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ <= '0;
    end else if (flush) begin
      r_occ <= '0;
    end else if (w_in_xfer && !w_out_xfer) begin
      r_occ <= r_occ + CntOne;
    end else if (w_out_xfer && !w_in_xfer) begin
      r_occ <= r_occ - CntOne;
    end
  end

  assign r_count = 1'b0;
  assign count   = r_occ;
`endif

endmodule

// File: tb/tb_pipe_register.sv
// Directed self-checking bench for pipe_register (WIDTH=32, STAGES=3).
// Count checks are active when PIPE_REG_COUNT_EN is defined.
module tb_pipe_register;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
`ifdef PIPE_REG_COUNT_EN
  logic [1:0]  count;
`endif

  int n_checks = 0;
  int n_err    = 0;

  pipe_register #(
    .WIDTH    (32),
    .STAGES   (3),
    .RESET_VAL(32'h0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef PIPE_REG_COUNT_EN
    .count    (count),
`endif
    .out_data (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input int exp);
`ifdef PIPE_REG_COUNT_EN
    chk(tag, 32'(count), 32'(exp));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #10;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk_cnt("rst_count", 0);
    #1 rst_n = 1'b1;
    step();

    // Stream: back-to-back 1..8 with out_ready held high
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1; in_data = 32'(k);
      #1 chk("stream_in_ready", 32'(in_ready), 32'd1);
      step();
      if (k >= 3) begin
        chk("stream_out_valid", 32'(out_valid), 32'd1);
        chk("stream_out_data", out_data, 32'(k - 2));
        chk_cnt("stream_count", 3);
      end else begin
        chk("stream_fill_valid", 32'(out_valid), 32'd0);
        chk_cnt("stream_fill_count", k);
      end
    end
    in_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      step();
      if (j < 2) begin
        chk("drain_out_valid", 32'(out_valid), 32'd1);
        chk("drain_out_data", out_data, 32'(7 + j));
      end else begin
        chk("drain_empty", 32'(out_valid), 32'd0);
      end
      chk_cnt("drain_count", 2 - j);
    end

    // Backpressure: A,B,C accepted, D refused while full
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 32'hA + 32'(k);
      #1 chk("bp_in_ready_fill", 32'(in_ready), 32'd1);
      step();
    end
    in_data = 32'hD;
    #1 chk("bp_in_ready_full", 32'(in_ready), 32'd0);
    chk_cnt("bp_count_full", 3);
    chk("bp_head", out_data, 32'hA);
    step();
    chk("bp_stable_valid", 32'(out_valid), 32'd1);
    chk("bp_stable_data", out_data, 32'hA);
    chk_cnt("bp_count_hold", 3);
    out_ready = 1'b1;
    #1 chk("bp_in_ready_release", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp_out_b", out_data, 32'hB);
    chk_cnt("bp_count_swap", 3);
    step();
    chk("bp_out_c", out_data, 32'hC);
    step();
    chk("bp_out_d", out_data, 32'hD);
    chk("bp_out_d_valid", 32'(out_valid), 32'd1);
    step();
    chk("bp_empty", 32'(out_valid), 32'd0);
    chk_cnt("bp_count_empty", 0);

    // Bubble collapse: 0x10, two idle cycles, 0x20, then one idle edge to compact
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h10;
    step();
    in_valid = 1'b0;
    step();
    step();
    in_valid = 1'b1; in_data = 32'h20;
    step();
    in_valid = 1'b0;
    step();
    chk_cnt("bub_count", 2);
    chk("bub_in_ready", 32'(in_ready), 32'd1);
    chk("bub_head", out_data, 32'h10);
    out_ready = 1'b1;
    step();
    chk("bub_second_valid", 32'(out_valid), 32'd1);
    chk("bub_second_data", out_data, 32'h20);
    step();
    chk("bub_empty", 32'(out_valid), 32'd0);

    // Full pass-through: full chain, simultaneous in and out
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 32'h31 + 32'(k);
      step();
    end
    in_data = 32'h34; out_ready = 1'b1;
    #1 chk("pt_in_ready", 32'(in_ready), 32'd1);
    chk("pt_head", out_data, 32'h31);
    step();
    chk("pt_next", out_data, 32'h32);
    chk_cnt("pt_count", 3);

    // Flush while full with a beat offered
    in_valid = 1'b1; in_data = 32'h99; flush = 1'b1;
    #1 chk("fl_in_ready", 32'(in_ready), 32'd0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_data_held", out_data, 32'h32);
    chk_cnt("fl_count", 0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("fl_no_ghost", 32'(out_valid), 32'd0);
    end

    // Reset mid-stream, then latency of first beat after release
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = 32'h41 + 32'(k);
      step();
    end
    chk("rs_pre_data", out_data, 32'h42);
    #3 rst_n = 1'b0;
    #1;
    chk("rs_async_valid", 32'(out_valid), 32'd0);
    chk("rs_async_data", out_data, 32'h0);
    chk_cnt("rs_async_count", 0);
    #2 rst_n = 1'b1;
    in_valid = 1'b1; in_data = 32'h55;
    #1 chk("rs_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("rs_lat1", 32'(out_valid), 32'd0);
    step();
    chk("rs_lat2", 32'(out_valid), 32'd0);
    step();
    chk("rs_lat3_valid", 32'(out_valid), 32'd1);
    chk("rs_lat3_data", out_data, 32'h55);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
